// File: rtl/cpu_pkg.sv
// cpu_pkg: Hack C-instruction field positions and source-select types shared by the pipeline
package cpu_pkg;
  localparam int C_BIT = 15;
  localparam int EXT_BIT = 14;
  localparam int A_BIT = 12;
  localparam int ALU_LSB = 6;
  localparam int DEST_LSB = 3;
  localparam int JMP_LSB = 0;
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} ss_state_t;
endpackage

// File: rtl/ss_outreg.sv
// ss_outreg: valid/ready output register with a one-entry holding slot for loads that arrive while occupied
module ss_outreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] din,
  input  logic         rdy,
  output logic         vld,
  output logic         full,
  output logic [W-1:0] dout
);
  logic [W-1:0] hold;
  logic free;
  assign free = !vld || rdy;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld <= 1'b0;
      full <= 1'b0;
      dout <= '0;
      hold <= '0;
    end else if (free) begin
      vld <= full || ld;
      if (full || ld) dout <= full ? hold : din;
      full <= full && ld;
      if (full && ld) hold <= din;
    end else if (ld && !full) begin
      hold <= din;
      full <= 1'b1;
    end
endmodule

// File: rtl/ss_pipe.sv
// ss_pipe: registered ALU source select; fetches M itself when the a-bit asks for it
module ss_pipe import cpu_pkg::*; #(
  parameter int D_W = 16,
  parameter int EXT_EN = 0,
  parameter int TO_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [D_W-1:0] inst,
  input  logic           inst_vld,
  output logic           inst_rdy,
  input  logic [D_W-1:0] A,
  input  logic [D_W-1:0] D,
  input  logic [D_W-1:0] PC,
  output logic           m_req_vld,
  input  logic           m_req_rdy,
  output logic [D_W-1:0] m_addr,
  input  logic [D_W-1:0] M,
  input  logic           M_vld,
  output logic           vld_m,
  input  logic           rdy_m,
  output logic [D_W-1:0] x_m,
  output logic [D_W-1:0] y_m,
  output logic           zx_m,
  output logic           nx_m,
  output logic           zy_m,
  output logic           ny_m,
  output logic           f_m,
  output logic           no_m,
  output logic [2:0]     dest_m,
  output logic [2:0]     jmp_m,
  output logic           err
);
  localparam int OW = 2 * D_W + 12;
  localparam logic [TO_W-1:0] TO_LAST = {TO_W{1'b1}} - 1'b1;
  ss_state_t state, nxt;
  logic [TO_W-1:0] cnt;
  logic [D_W-1:0] c_x, c_a, sel_x;
  logic [11:0] c_ctl;
  logic [OW-1:0] din, dout;
  logic free, acc, ld, full, to, unused;
  alu_ctrl_t ctl;
  assign unused = ^inst;
  assign free = !vld_m || rdy_m;
  assign inst_rdy = state == IDLE && free;
  assign acc = inst_vld && inst_rdy;
  assign sel_x = (EXT_EN != 0 && !inst[EXT_BIT]) ? PC : D;
  assign m_req_vld = state == REQ;
  assign m_addr = c_a;
  always_comb begin
    nxt = state;
    ld = 1'b0;
    to = 1'b0;
    din = {sel_x, A, inst[ALU_LSB+5:JMP_LSB]};
    case (state)
      IDLE: begin
        ld = acc && inst[C_BIT] && !inst[A_BIT];
        nxt = (acc && inst[C_BIT] && inst[A_BIT]) ? REQ : IDLE;
      end
      REQ: nxt = m_req_rdy ? WAIT : REQ;
      default: begin
        // a held response drains first; a second M_vld while holding is ignored
        din = {c_x, M, c_ctl};
        ld = M_vld && !full;
        to = !full && !M_vld && cnt == TO_LAST;
        nxt = (((full || M_vld) && free) || to) ? IDLE : WAIT;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      err <= 1'b0;
      c_x <= '0;
      c_a <= '0;
      c_ctl <= '0;
    end else begin
      state <= nxt;
      cnt <= (state == WAIT && nxt == WAIT && !full) ? cnt + 1'b1 : '0;
      err <= err || to;
      if (state == IDLE && nxt == REQ) begin
        c_x <= sel_x;
        c_a <= A;
        c_ctl <= inst[ALU_LSB+5:JMP_LSB];
      end
    end
  ss_outreg #(.W(OW)) u_out (
    .clk(clk),
    .rst(rst),
    .ld(ld),
    .din(din),
    .rdy(rdy_m),
    .vld(vld_m),
    .full(full),
    .dout(dout)
  );
  assign x_m = dout[OW-1 -: D_W];
  assign y_m = dout[D_W+11:12];
  assign ctl = alu_ctrl_t'(dout[11:6]);
  assign zx_m = ctl.zx;
  assign nx_m = ctl.nx;
  assign zy_m = ctl.zy;
  assign ny_m = ctl.ny;
  assign f_m = ctl.f;
  assign no_m = ctl.no;
  assign dest_m = dout[5:3];
  assign jmp_m = dout[2:0];
endmodule

// File: doc/ss_pipe.md
Name: ss_pipe

Overview:
- Registered successor to the CPU source-select stage. Accepts one decoded Hack C-instruction per handshake and produces ALU operands x/y plus ALU control bits through a valid/ready output register.
- When the a-bit selects M, the block issues its own data-memory read and waits for the response.
- Optional extended mode selects PC as the x operand.
- Sits between the fetch/decode stage and the ALU in the CPU pipeline.

Parameters:
- D_W, 16, datapath and instruction width; must be >= 16.
- EXT_EN, 0, 1 enables PC-as-x mode via instruction bit 14.
- TO_W, 8, width of the memory-response watchdog counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- inst  in  D_W  instruction word.
- inst_vld  in  1  instruction valid.
- inst_rdy  out  1  instruction accepted when inst_vld && inst_rdy.
- A  in  D_W  A register value, sampled at accept.
- D  in  D_W  D register value, sampled at accept.
- PC  in  D_W  PC value, sampled at accept.
- m_req_vld  out  1  memory read request valid.
- m_req_rdy  in  1  memory read request accepted.
- m_addr  out  D_W  read address, equal to the captured A.
- M  in  D_W  read data.
- M_vld  in  1  read data valid, single-cycle pulse.
- vld_m  out  1  output valid.
- rdy_m  in  1  ALU ready.
- x_m  out  D_W  x operand.
- y_m  out  D_W  y operand.
- zx_m, nx_m, zy_m, ny_m, f_m, no_m  out  1 each  ALU controls, taken from inst[11:6].
- dest_m  out  3  destination field inst[5:3].
- jmp_m  out  3  jump field inst[2:0].
- err  out  1  sticky watchdog error.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; watchdog counter 0.
- FSM states: IDLE, REQ, WAIT.
- inst_rdy = (state==IDLE) && (!vld_m || rdy_m). The output register therefore either is empty or drains in the same cycle as an accept.
- Accept, inst[15]==0 (A-instruction): consumed and dropped. No output, FSM stays in IDLE.
- Accept, C-instruction with a-bit inst[12]==0:
  - Output register loads at the same edge; vld_m high next cycle.
  - y_m = A.
  - x_m = D, except x_m = PC when EXT_EN==1 and inst[14]==0.
  - Latency 1; throughput 1 per cycle.
- Accept, C-instruction with a-bit inst[12]==1:
  - Capture inst, D, PC and A; go to REQ.
  - REQ: m_req_vld=1, m_addr=captured A. On m_req_rdy go to WAIT.
  - WAIT: on M_vld, load the output register with y_m=M and x_m per the rule above; go to IDLE.
  - vld_m rises the cycle after M_vld.
- Output hold: while vld_m && !rdy_m, every output field is stable.
- vld_m clears on rdy_m unless a new load happens at the same edge.
- In REQ/WAIT the output register may still hold and drain an earlier result; the new load never overwrites an undrained result. The block loads only when !vld_m || rdy_m at the M_vld cycle.
- If the output is still occupied when M_vld arrives, M is captured into a 1-entry holding register. The output loads when it frees, then the FSM returns to IDLE.
- M_vld outside WAIT is ignored.
- Watchdog:
  - Counter increments every cycle in WAIT and clears on leaving WAIT.
  - When it reaches 2^TO_W-1: err is set (sticky until rst), the FSM returns to IDLE, and the instruction is dropped.
  - A late M_vld after that point is ignored.
- rst mid-operation: immediately returns to IDLE and clears vld_m, m_req_vld, the holding register and err. An outstanding memory response after reset is ignored.
- No arithmetic on operands: pure selection. PC is used at full width with no increment.

Decomposition:
- Shared package cpu_pkg:
  - Field positions: C_BIT=15, EXT_BIT=14, A_BIT=12, ALU_LSB=6, DEST_LSB=3, JMP_LSB=0.
  - Typedef alu_ctrl_t: packed zx, nx, zy, ny, f, no.
  - Enum ss_state_t: IDLE, REQ, WAIT.
- Sub-module ss_outreg: valid/ready output register with the 1-entry holding register, reused by later pipeline stages.

Test Plan:
- Reset, then 3 back-to-back C-instructions (a=0), with A=0x0010, D=0x0005, rdy_m=1 -> vld_m high on 3 consecutive cycles, each with x_m=0x0005, y_m=0x0010; inst_rdy never drops.
- Inst 0xFC10 (a=1), A=0x0100, m_req_rdy=1, M=0x1234 with M_vld 4 cycles after the request -> m_addr=0x0100, y_m=0x1234 the cycle after M_vld, ALU controls = inst[11:6].
- rdy_m low for 5 cycles with vld_m high -> all outputs stable and inst_rdy=0; rdy_m=1 -> drains, next instruction accepted at the same edge.
- EXT_EN=1, inst[14]=0, PC=0x0042 -> x_m=0x0042; same stimulus with EXT_EN=0 -> x_m=D.
- TO_W=3, M_vld withheld -> err=1 after 7 cycles in WAIT, FSM in IDLE; a later M_vld produces no vld_m.
- Assert rst during WAIT -> next cycle vld_m=0, m_req_vld=0, err=0, inst_rdy=1; an A-instruction 0x0007 afterwards produces no output.
